dmu_mmio_ctrl: RTL and testbench
================================

Name: dmu_mmio_ctrl

Overview:
Parametrised data-memory unit with a request/response handshake. It sits between the CPU MEM stage and an internal word-organised data RAM, and routes accesses in the I/O window to the I/O bus. Compared with the single-cycle unit it adds:
- byte, half and word accesses with sign or zero extension on loads;
- read-modify-write for sub-word stores;
- a handshaked I/O bus with an I/O timeout;
- alignment and range error detection, plus a sticky error flag.

Parameters:
ADDR_W, 16, byte-address width of req_addr and io_addr.
DM_DEPTH, 1024, data RAM depth in 32-bit words (power of two).
IO_TAG, 8'hFF, value of req_addr[ADDR_W-1:ADDR_W-8] that selects the I/O window.
IO_TIMEOUT, 15, maximum number of cycles to wait for io_ack (1..255).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  access request
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word (11 is illegal and errors)
req_unsigned  in  1  zero-extend loads
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; sub-word data is taken from the low bits
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  load result (0 for stores and errors)
resp_err  out  1  error qualifier, valid with resp_valid
io_addr  out  ADDR_W  I/O address
io_dout  out  32  I/O write data
io_we  out  1  I/O write strobe
io_rd  out  1  I/O read strobe
io_din  in  32  I/O read data
io_ack  in  1  I/O completion
debug_addr  in  clog2(DM_DEPTH)  debug word address
debug_dout  out  32  registered debug read data
dmu_error  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1 once released; resp_valid, resp_err, io_we, io_rd, dmu_error = 0; resp_rdata, io_addr, io_dout, debug_dout = 0; timeout counter 0. RAM contents are not reset.
- Reset mid-operation: the FSM aborts immediately and no response is issued. An RMW whose write cycle has not occurred leaves the RAM word unchanged.
- A request is accepted on a clock edge where req_valid & req_ready. All request fields are latched at acceptance. req_valid while busy is ignored.
- Decode at acceptance: IO if the top 8 address bits equal IO_TAG; DM otherwise. DM word index = req_addr[ADDR_W-1:2].
- Errors are raised, with no RAM or IO side effect, for:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - req_size=11;
  - DM word index ≥ DM_DEPTH;
  - any non-word IO access.
  Error response: state ERR, resp_valid=1 and resp_err=1 in the cycle after acceptance, resp_rdata=0, dmu_error set.
- FSM states: IDLE, DM_RD, DM_WR, IO_WAIT, RESP, ERR. Every non-IDLE path returns to IDLE after its resp_valid cycle.
- DM load: IDLE→DM_RD (synchronous RAM read)→RESP. resp_valid occurs 2 cycles after acceptance.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend unless req_unsigned=1.
- DM word store: the RAM write happens in the cycle after acceptance; RESP follows. resp_valid occurs 2 cycles after acceptance.
- DM sub-word store: IDLE→DM_RD (read)→DM_WR (merge the byte or half into its lane and write the full word)→RESP. resp_valid occurs 3 cycles after acceptance.
- IO access: IDLE→IO_WAIT.
  - io_addr and io_dout are driven from the latched request.
  - io_rd (load) or io_we (store) is held high through every IO_WAIT cycle.
  - The counter increments each IO_WAIT cycle.
  - On io_ack: strobes drop the next cycle, io_din is captured on the ack edge, and the unit goes to RESP with err=0.
  - If the counter reaches IO_TIMEOUT without io_ack: strobes drop and the unit goes to ERR (rdata=0, dmu_error set).
  - io_ack in the same cycle the counter reaches IO_TIMEOUT: the ack wins.
  - io_ack outside IO_WAIT is ignored.
- Debug port: debug_dout = RAM[debug_addr], registered with 1-cycle latency, independent of the FSM. A same-cycle write to the same word returns the old data.
- dmu_error is cleared only by rst.

Test Plan:
- Store word 0x12345678 to addr 0x0010, then load byte unsigned from 0x0013 → resp_rdata=0x00000012, err=0. The store response comes 2 cycles after acceptance; the load response also 2 cycles after acceptance.
- Store byte 0xAB to 0x0011 over word 0x12345678 (RMW, resp after 3 cycles) → word reads 0x1234AB78; load byte signed from 0x0011 → 0xFFFFFFAB.
- Load half from 0x0003 → resp_err=1 the cycle after acceptance, dmu_error=1 and it stays 1, RAM unchanged, no io strobe.
- IO load from 0xFF04 with io_ack after 3 cycles and io_din=0xCAFEF00D → io_rd high exactly 3 cycles, resp_rdata=0xCAFEF00D, err=0. req_valid asserted during this access is not accepted.
- IO store to 0xFF08 with io_ack never asserted → io_we high for 15 cycles, then resp_err=1 and rdata=0.
- Assert rst during DM_RD of a sub-word store to 0x0020 → no resp_valid, RAM word unchanged (checked via debug_addr=8, debug_dout after 1 cycle), req_ready=1 after release.

Source files
------------

// File: rtl/dmu_mmio_ctrl.sv
// Data-memory unit with request/response handshake: byte/half/word access to an
// internal word RAM (RMW for sub-word stores), a handshaked I/O window with timeout.
module dmu_mmio_ctrl #(
    parameter int          ADDR_W     = 16,
    parameter int          DM_DEPTH   = 1024,
    parameter logic [7:0]  IO_TAG     = 8'hFF,
    parameter int          IO_TIMEOUT = 15,
    localparam int         AW         = $clog2(DM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] io_addr,
    output logic [31:0]       io_dout,
    output logic              io_we,
    output logic              io_rd,
    input  logic [31:0]       io_din,
    input  logic              io_ack,
    input  logic [AW-1:0]     debug_addr,
    output logic [31:0]       debug_dout,
    output logic              dmu_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_DM_RD, S_DM_WR, S_IO_WAIT, S_RESP, S_ERR
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [1:0]        r_lane;
    logic [AW-1:0]     r_idx;
    logic [15:0]       r_wdata;
    logic [31:0]       r_wr_word;
    logic [31:0]       r_rdata;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_io_addr;
    logic [31:0]       r_io_dout;
    logic [31:0]       r_debug_dout;
    logic              r_dmu_error;
    logic [31:0]       r_ram [DM_DEPTH];
    logic [31:0]       r_ram_q;

    logic              w_accept;
    logic              w_is_io;
    logic              w_req_err;
    logic [AW-1:0]     w_rd_idx;
    logic [7:0]        w_cnt_inc;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_val;
    logic [31:0]       w_merged;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_is_io   = (req_addr[ADDR_W-1 -: 8] == IO_TAG);
    assign w_req_err = (req_size == 2'b11)
                    || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                    || (!w_is_io && (32'(req_addr[ADDR_W-1:2]) >= 32'(DM_DEPTH)))
                    || (w_is_io && req_size != 2'b10);
    assign w_cnt_inc = r_cnt + 8'd1;
    // The RAM is read at acceptance so the word is already waiting in DM_RD.
    assign w_rd_idx  = (r_state == S_IDLE) ? req_addr[AW+1:2] : r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)             w_state_next = S_ERR;
                    else if (w_is_io)          w_state_next = S_IO_WAIT;
                    else if (!req_we)          w_state_next = S_DM_RD;
                    else if (req_size == 2'b10) w_state_next = S_DM_WR;
                    else                       w_state_next = S_DM_RD;
                end
            end
            S_DM_RD:   w_state_next = r_we ? S_DM_WR : S_RESP;
            S_DM_WR:   w_state_next = S_RESP;
            S_IO_WAIT: begin
                // An ack arriving on the final counted cycle still completes normally.
                if (io_ack)                            w_state_next = S_RESP;
                else if (w_cnt_inc == 8'(IO_TIMEOUT))  w_state_next = S_ERR;
            end
            S_RESP:    w_state_next = S_IDLE;
            S_ERR:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
        resp_err   = (r_state == S_ERR);
        resp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
        io_rd      = (r_state == S_IO_WAIT) && !r_we;
        io_we      = (r_state == S_IO_WAIT) && r_we;
    end

    assign io_addr    = r_io_addr;
    assign io_dout    = r_io_dout;
    assign debug_dout = r_debug_dout;
    assign dmu_error  = r_dmu_error;

    always_comb begin
        w_shifted  = r_ram_q >> {r_lane, 3'b000};
        w_load_val = r_ram_q;
        case (r_size)
            2'b00:   w_load_val = r_uns ? {24'd0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_val = r_uns ? {16'd0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_val = r_ram_q;
        endcase
    end

    always_comb begin
        w_merged = r_ram_q;
        if (r_size == 2'b00) w_merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
        else                 w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_lane       <= 2'b00;
            r_idx        <= '0;
            r_wdata      <= 16'd0;
            r_wr_word    <= 32'd0;
            r_rdata      <= 32'd0;
            r_cnt        <= 8'd0;
            r_io_addr    <= '0;
            r_io_dout    <= 32'd0;
            r_debug_dout <= 32'd0;
            r_dmu_error  <= 1'b0;
        end else begin
            r_debug_dout <= r_ram[debug_addr];
            if (w_accept) begin
                r_we      <= req_we;
                r_size    <= req_size;
                r_uns     <= req_unsigned;
                r_lane    <= req_addr[1:0];
                r_idx     <= req_addr[AW+1:2];
                r_wdata   <= req_wdata[15:0];
                r_wr_word <= req_wdata;
                r_rdata   <= 32'd0;
                r_cnt     <= 8'd0;
                if (w_is_io && !w_req_err) begin
                    r_io_addr <= req_addr;
                    r_io_dout <= req_wdata;
                end
            end
            if (r_state == S_DM_RD) begin
                if (r_we) r_wr_word <= w_merged;
                else      r_rdata   <= w_load_val;
            end
            if (r_state == S_IO_WAIT) begin
                r_cnt <= w_cnt_inc;
                if (io_ack && !r_we) r_rdata <= io_din;
            end
            if (w_state_next == S_ERR) r_dmu_error <= 1'b1;
        end
    end

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (r_state == S_DM_WR) r_ram[r_idx] <= r_wr_word;
        r_ram_q <= r_ram[w_rd_idx];
    end

endmodule

// File: tb/tb_dmu_mmio_ctrl.sv
// Directed plus randomized bench for dmu_mmio_ctrl, checked against a
// word-array reference model of the memory and I/O window.
module tb_dmu_mmio_ctrl;
    localparam int ADDR_W     = 16;
    localparam int DM_DEPTH   = 1024;
    localparam int IO_TIMEOUT = 15;
    localparam int AW         = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] io_addr;
    logic [31:0]       io_dout;
    logic              io_we;
    logic              io_rd;
    logic [31:0]       io_din = '0;
    logic              io_ack = 1'b0;
    logic [AW-1:0]     debug_addr = '0;
    logic [31:0]       debug_dout;
    logic              dmu_error;

    dmu_mmio_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
        .io_rd(io_rd), .io_din(io_din), .io_ack(io_ack), .debug_addr(debug_addr),
        .debug_dout(debug_dout), .dmu_error(dmu_error)
    );

    always #5 clk = ~clk;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] model_mem [DM_DEPTH];
    bit          model_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [1:0] size, input logic [15:0] addr);
        bit is_io;
        is_io = (addr >> 8) == 16'h00FF;
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
        if (!is_io && (int'(addr) / 4) >= DM_DEPTH) return 1'b1;
        if (is_io && size != 2'd2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [15:0] addr,
                                             input logic [1:0] size, input bit uns);
        longint nbits, mask, v;
        nbits = 8 * (longint'(1) << size);
        mask  = (longint'(1) << nbits) - 1;
        v     = (longint'(word) >> (8 * (addr % 4))) & mask;
        if (!uns && ((v >> (nbits - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [15:0] addr,
                                              input logic [1:0] size, input logic [31:0] wdata);
        longint nbits, m, r;
        nbits = 8 * (longint'(1) << size);
        m     = ((longint'(1) << nbits) - 1) << (8 * (addr % 4));
        r     = (longint'(word) & ~m) | ((longint'(wdata) << (8 * (addr % 4))) & m);
        return r[31:0];
    endfunction

    // One request/response; ack_dly = IO_WAIT cycle in which io_ack is given (0 = never).
    task automatic txn(input bit we, input logic [1:0] size, input bit uns,
                       input logic [15:0] addr, input logic [31:0] wdata,
                       input int ack_dly, input logic [31:0] din, input bit poke);
        bit          e_err, is_io, got;
        int          e_lat, e_strb, lat, strobes;
        logic [31:0] e_rdata, g_rdata;
        logic        g_err, g_dmu;
        int          idx;
        is_io   = (addr >> 8) == 16'h00FF;
        e_err   = ref_err(size, addr);
        idx     = int'(addr) / 4;
        e_rdata = 32'd0;
        e_strb  = 0;
        if (e_err) e_lat = 1;
        else if (is_io) begin
            if (ack_dly != 0) begin
                e_lat = ack_dly + 1; e_strb = ack_dly;
                if (!we) e_rdata = din;
            end else begin
                e_lat = IO_TIMEOUT + 1; e_strb = IO_TIMEOUT; e_err = 1'b1;
            end
        end else if (!we) begin
            e_lat = 2; e_rdata = ref_load(model_mem[idx], addr, size, uns);
        end else e_lat = (size == 2'd2) ? 2 : 3;
        if (e_err) model_err = 1'b1;

        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = poke;
        if (poke) begin req_we = 1'b0; req_size = 2'd2; req_addr = 16'h0000; end
        got = 1'b0; lat = 1; strobes = 0; g_rdata = 'x; g_err = 1'bx; g_dmu = 1'bx;
        while (!got && lat <= 40) begin
            io_ack = 1'b0;
            if (poke) chk("ready_busy", 32'(req_ready), 32'(resp_valid & 1'b0));
            if (io_rd || io_we) begin
                strobes++;
                chk("io_kind", 32'(io_we), 32'(we));
                chk("io_addr", 32'(io_addr), 32'(addr));
                if (we) chk("io_dout", io_dout, wdata);
                if (strobes == ack_dly) begin io_ack = 1'b1; io_din = din; end
            end
            if (resp_valid) begin
                got = 1'b1; g_rdata = resp_rdata; g_err = resp_err; g_dmu = dmu_error;
                req_valid = 1'b0; io_ack = 1'b0;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        chk("resp_latency", 32'(lat), 32'(e_lat));
        chk("resp_rdata", g_rdata, e_rdata);
        chk("resp_err", 32'(g_err), 32'(e_err));
        chk("io_strobes", 32'(strobes), 32'(e_strb));
        chk("dmu_error", 32'(g_dmu), 32'(model_err));
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        if (!e_err && !is_io && we) model_mem[idx] = ref_store(model_mem[idx], addr, size, wdata);
        $display("[TB] txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 we, size, uns, addr, wdata, g_rdata, g_err, lat);
    endtask

    task automatic dbg_chk(input int idx);
        @(negedge clk);
        debug_addr = AW'(idx);
        @(negedge clk);
        chk("debug_dout", debug_dout, model_mem[idx]);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_io_strobes", 32'({io_we, io_rd}), 32'd0);
        chk("rst_io_addr", 32'(io_addr), 32'd0);
        chk("rst_io_dout", io_dout, 32'd0);
        chk("rst_debug_dout", debug_dout, 32'd0);
        chk("rst_dmu_error", 32'(dmu_error), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Preload the low 64 words so the model knows their contents
        for (int i = 0; i < 64; i++) txn(1'b1, 2'd2, 1'b0, 16'(i * 4), $urandom, 0, 32'd0, 1'b0);

        // Directed cases
        txn(1'b1, 2'd2, 1'b0, 16'h0010, 32'h12345678, 0, 32'd0, 1'b0);
        txn(1'b0, 2'd0, 1'b1, 16'h0013, 32'd0, 0, 32'd0, 1'b0);
        txn(1'b1, 2'd0, 1'b0, 16'h0011, 32'h000000AB, 0, 32'd0, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 0, 32'd0, 1'b0);
        chk("rmw_word", model_mem[4], 32'h1234AB78);
        txn(1'b0, 2'd0, 1'b0, 16'h0011, 32'd0, 0, 32'd0, 1'b0);
        txn(1'b0, 2'd1, 1'b0, 16'h0003, 32'd0, 0, 32'd0, 1'b0);
        dbg_chk(0);
        txn(1'b0, 2'd2, 1'b0, 16'hFF04, 32'd0, 3, 32'hCAFEF00D, 1'b1);
        txn(1'b1, 2'd2, 1'b0, 16'hFF08, 32'h600DF00D, 0, 32'd0, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 16'hFF0C, 32'd0, IO_TIMEOUT, 32'h13579BDF, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 16'h1000, 32'd0, 0, 32'd0, 1'b0);
        txn(1'b1, 2'd0, 1'b0, 16'hFF10, 32'h11, 2, 32'd0, 1'b0);
        txn(1'b0, 2'd3, 1'b0, 16'h0020, 32'd0, 0, 32'd0, 1'b0);
        dbg_chk(4);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int          kind;
            logic [15:0] a;
            logic [1:0]  sz;
            kind = int'($urandom_range(0, 9));
            sz   = 2'($urandom_range(0, 3));
            if (kind <= 6)      a = 16'($urandom_range(0, 255));
            else if (kind == 7) a = 16'($urandom_range(16'h1000, 16'hFEFF));
            else begin
                a  = {8'hFF, 8'($urandom_range(0, 255))};
                if ($urandom_range(0, 3) != 0) begin sz = 2'd2; a[1:0] = 2'b00; end
            end
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                int'($urandom_range(0, 6)), $urandom, 1'b0);
            if (n % 10 == 0) dbg_chk(int'($urandom_range(0, 63)));
        end

        // Reset during DM_RD of a byte store: no response, word unchanged
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 16'h0020; req_wdata = 32'h0000005A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_dmu_error", 32'(dmu_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        chk("midrst_ready", 32'(req_ready), 32'd1);
        dbg_chk(8);
        txn(1'b0, 2'd0, 1'b0, 16'h0020, 32'd0, 0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
